uart_rx: RTL and testbench

Oversampling UART receiver; consumer side of the UART link whose transmit side and baud generation already exist. Samples the asynchronous `rx` line at 16x the baud rate, derived internally from `sys_clk`. Frames 8N1 characters LSB-first and presents each byte through a one-entry valid/ready holding register. Reports framing and overrun errors to the host logic.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_rx_if.sv | 20 ++
 rtl/uart_rx_tick.sv | 33 +++
 rtl/uart_rx.sv | 189 ++++++++++++++++++
 tb/tb_uart_rx.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared constants, state type and parity helper for the oversampling UART receiver.
// Defining UART_RX_PARITY_EN adds the even-parity state to the frame.
package uart_pkg;

    localparam int unsigned UART_OVS    = 16;
    localparam int unsigned UART_OS_W   = $clog2(UART_OVS);
    localparam int unsigned UART_DATA_W = 8;
    localparam int unsigned UART_BIT_W  = $clog2(UART_DATA_W);

    localparam logic [UART_OS_W-1:0] UART_MID  = UART_OS_W'(7);
    localparam logic [UART_OS_W-1:0] UART_LAST = UART_OS_W'(UART_OVS - 1);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StData   = 3'd2,
`ifdef UART_RX_PARITY_EN
        StParity = 3'd3,
`endif
        StStop   = 3'd4
    } uart_rx_state_e;

    // Even parity: the parity bit equals the XOR of the data bits.
    function automatic logic even_parity(input logic [UART_DATA_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// One-entry valid/ready byte channel from the UART receiver to its consumer.
interface uart_rx_if;

    logic [uart_pkg::UART_DATA_W-1:0] rx_data;
    logic                             rx_valid;
    logic                             rx_ready;

    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready
    );

endinterface

// File: rtl/uart_rx_tick.sv
// Oversample tick divider: counts 0..Div-1 and flags the last count; restart_i zeroes it.
module uart_rx_tick #(
    parameter int unsigned Div = 2
) (
    input  logic sys_clk,
    input  logic rst,
    input  logic restart_i,
    output logic tick_o
);

    localparam int unsigned CntW = (Div > 1) ? $clog2(Div) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(Div - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (restart_i || (cnt_q == CntLast)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == CntLast);

endmodule

// File: rtl/uart_rx.sv
// 16x oversampling 8-bit UART receiver with one-entry holding register and error flags.
// Defining UART_RX_PARITY_EN enables an even-parity bit and a live parity_err.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned SYS_CLK  = 30000000,
    parameter int unsigned BAUDRATE = 9600
) (
    input  logic      sys_clk,
    input  logic      rst,
    input  logic      rx,
    uart_rx_if.master rx_if,
    output logic      frame_err,
    output logic      parity_err,
    output logic      overrun,
    output logic      busy
);

    localparam int unsigned Div = SYS_CLK / (BAUDRATE * UART_OVS);

    uart_rx_state_e             state_q, state_d;
    logic [1:0]                 sync_q;
    logic [UART_OS_W-1:0]       os_q, os_d;
    logic [UART_BIT_W-1:0]      bit_q, bit_d;
    logic [UART_DATA_W-1:0]     sr_q, sr_d;
    logic [UART_DATA_W-1:0]     data_q, data_d;
    logic                       valid_q, valid_d;
    logic                       ferr_q, ferr_d;
    logic                       ovr_q, ovr_d;
    logic                       rxs, tick, restart, deliver, hs;
`ifdef UART_RX_PARITY_EN
    logic                       par_q, par_d;
    logic                       perr_q, perr_d;
`endif

    assign rxs = sync_q[1];
    assign hs  = valid_q && rx_if.rx_ready;

    uart_rx_tick #(
        .Div (Div)
    ) u_tick (
        .sys_clk   (sys_clk),
        .rst       (rst),
        .restart_i (restart),
        .tick_o    (tick)
    );

    always_comb begin
        state_d = state_q;
        os_d    = os_q;
        bit_d   = bit_q;
        sr_d    = sr_q;
        data_d  = data_q;
        valid_d = valid_q;
        ferr_d  = 1'b0;
        ovr_d   = ovr_q;
        restart = 1'b0;
        deliver = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d   = par_q;
        perr_d  = 1'b0;
`endif

        if (hs) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                os_d  = '0;
                bit_d = '0;
                if (!rxs) begin
                    state_d = StStart;
                    restart = 1'b1;
                end
            end
            StStart: begin
                if (tick) begin
                    os_d = os_q + 1'b1;
                    if (os_q == UART_MID) begin
                        os_d    = '0;
                        state_d = rxs ? StIdle : StData;
                    end
                end
            end
            StData: begin
                if (tick) begin
                    os_d = os_q + 1'b1;
                    if (os_q == UART_LAST) begin
                        sr_d  = {rxs, sr_q[UART_DATA_W-1:1]};
                        bit_d = bit_q + 1'b1;
                        if (bit_q == UART_BIT_W'(UART_DATA_W - 1)) begin
`ifdef UART_RX_PARITY_EN
                            state_d = StParity;
`else
                            state_d = StStop;
`endif
                        end
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            StParity: begin
                if (tick) begin
                    os_d = os_q + 1'b1;
                    if (os_q == UART_LAST) begin
                        par_d   = rxs;
                        state_d = StStop;
                    end
                end
            end
`endif
            StStop: begin
                if (tick) begin
                    os_d = os_q + 1'b1;
                    if (os_q == UART_LAST) begin
                        // Leave at mid stop bit so a back-to-back start edge is not missed.
                        state_d = StIdle;
                        if (!rxs) begin
                            ferr_d = 1'b1;
`ifdef UART_RX_PARITY_EN
                        end else if (even_parity(sr_q) != par_q) begin
                            perr_d = 1'b1;
`endif
                        end else begin
                            deliver = 1'b1;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // A same-cycle handshake frees the slot; otherwise the new byte is lost.
        if (deliver) begin
            if (!valid_q || rx_if.rx_ready) begin
                data_d  = sr_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q <= StIdle;
            sync_q  <= 2'b11;
            os_q    <= '0;
            bit_q   <= '0;
            sr_q    <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sync_q  <= {sync_q[0], rx};
            os_q    <= os_d;
            bit_q   <= bit_d;
            sr_q    <= sr_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
`ifdef UART_RX_PARITY_EN
            par_q   <= par_d;
            perr_q  <= perr_d;
`endif
        end
    end

    assign rx_if.rx_data  = data_q;
    assign rx_if.rx_valid = valid_q;
    assign frame_err      = ferr_q;
    assign overrun        = ovr_q;
    assign busy           = (state_q != StIdle);
`ifdef UART_RX_PARITY_EN
    assign parity_err     = perr_q;
`else
    assign parity_err     = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frame-level reference model feeds queues, monitor pops on events.
// Builds with or without UART_RX_PARITY_EN to match the RTL.
module tb_uart_rx;

    localparam int unsigned SysClk = 1600000;
    localparam int unsigned Baud   = 10000;
    localparam int          BitCyc = 160;
`ifdef UART_RX_PARITY_EN
    localparam bit ParEn   = 1'b1;
    localparam int Latency = 2 + 10 * (8 + 16 * 10) + 1;
`else
    localparam bit ParEn   = 1'b0;
    localparam int Latency = 2 + 10 * (8 + 16 * 9) + 1;
`endif

    logic sys_clk = 1'b0;
    logic rst     = 1'b1;
    logic rx      = 1'b1;
    logic frame_err, parity_err, overrun, busy;

    uart_rx_if rx_if ();

    uart_rx #(
        .SYS_CLK  (SysClk),
        .BAUDRATE (Baud)
    ) dut (
        .sys_clk    (sys_clk),
        .rst        (rst),
        .rx         (rx),
        .rx_if      (rx_if),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    always #5 sys_clk = ~sys_clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always @(posedge sys_clk) cyc <= cyc + 1;

    // Expected bytes (popped on handshake) and error pulses (2'b10 frame, 2'b01 parity).
    logic [7:0] byte_q[$];
    logic [1:0] err_q[$];
    logic       held    = 1'b0;
    logic       ovr_exp = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    logic [1:0] mon_e;
    logic [7:0] mon_b;

    always @(negedge sys_clk) begin
        if (!rst) begin
            if (frame_err || parity_err) begin
                check("err_expected", 32'(err_q.size() != 0), 1);
                if (err_q.size() != 0) begin
                    mon_e = err_q.pop_front();
                    check("err_kind", {30'd0, frame_err, parity_err}, {30'd0, mon_e});
                end
            end
            if (rx_if.rx_valid && rx_if.rx_ready) begin
                check("byte_expected", 32'(byte_q.size() != 0), 1);
                if (byte_q.size() != 0) begin
                    mon_b = byte_q.pop_front();
                    check("byte_data", {24'd0, rx_if.rx_data}, {24'd0, mon_b});
                end
            end
        end
    end

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic hold(input int n);
        repeat (n) step();
    endtask

    task automatic set_ready(input logic v);
        rx_if.rx_ready = v;
        if (v) begin
            held    = 1'b0;
            ovr_exp = 1'b0;
        end
    endtask

    task automatic pulse_ready();
        set_ready(1'b1);
        step();
        rx_if.rx_ready = 1'b0;
    endtask

    // Frame-level outcome: error pulse, delivered byte, or overrun when the slot is occupied.
    task automatic model_frame(input logic [7:0] d, input logic par, input logic stop);
        if (!stop) err_q.push_back(2'b10);
        else if (ParEn && (par != ^d)) err_q.push_back(2'b01);
        else if (rx_if.rx_ready) byte_q.push_back(d);
        else if (held) ovr_exp = 1'b1;
        else begin
            held = 1'b1;
            byte_q.push_back(d);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
        rx = 1'b0;
        hold(BitCyc);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            hold(BitCyc);
        end
        if (ParEn) begin
            rx = par;
            hold(BitCyc);
        end
        rx = stop;
        hold(BitCyc);
        rx = 1'b1;
    endtask

    task automatic after_frame(input string tag);
        hold(100);
        @(negedge sys_clk);
        check({tag, "_valid"}, {31'd0, rx_if.rx_valid}, {31'd0, held});
        check({tag, "_overrun"}, {31'd0, overrun}, {31'd0, ovr_exp});
        check({tag, "_busy"}, {31'd0, busy}, 0);
        step();
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] d;
        logic       par, stop, found;
        int         t0, lat;

        rx_if.rx_ready = 1'b0;
        hold(5);
        @(negedge sys_clk);
        check("rst_valid", {31'd0, rx_if.rx_valid}, 0);
        check("rst_data", {24'd0, rx_if.rx_data}, 0);
        check("rst_frame_err", {31'd0, frame_err}, 0);
        check("rst_parity_err", {31'd0, parity_err}, 0);
        check("rst_overrun", {31'd0, overrun}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        step();
        rst = 1'b0;
        hold(10);

        // 0xA5 with ready low: latency, hold, single-cycle accept.
        d = 8'hA5;
        model_frame(d, ^d, 1'b1);
        t0 = cyc;
        found = 1'b0;
        lat = 0;
        fork
            send_frame(d, ^d, 1'b1);
            begin
                for (int i = 0; i < Latency + 100 && !found; i++) begin
                    @(negedge sys_clk);
                    if (rx_if.rx_valid) begin
                        found = 1'b1;
                        lat   = cyc - t0;
                    end
                end
            end
        join
        check("a5_seen", {31'd0, found}, 1);
        check("a5_latency", (lat >= Latency - 10 && lat <= Latency + 10) ? Latency : lat, Latency);
        hold(50);
        @(negedge sys_clk);
        check("a5_held_valid", {31'd0, rx_if.rx_valid}, 1);
        check("a5_held_data", {24'd0, rx_if.rx_data}, 32'hA5);
        step();
        pulse_ready();
        @(negedge sys_clk);
        check("a5_valid_drop", {31'd0, rx_if.rx_valid}, 0);
        step();

        // Short low pulse is rejected at mid start bit.
        rx = 1'b0;
        hold(20);
        @(negedge sys_clk);
        check("glitch_busy_high", {31'd0, busy}, 1);
        step();
        hold(19);
        rx = 1'b1;
        after_frame("glitch");

        // Stop bit low.
        d = 8'h3C;
        model_frame(d, ^d, 1'b0);
        send_frame(d, ^d, 1'b0);
        after_frame("ferr");

        // Back-to-back frames into a full slot.
        model_frame(8'h11, ^8'h11, 1'b1);
        send_frame(8'h11, ^8'h11, 1'b1);
        model_frame(8'h22, ^8'h22, 1'b1);
        send_frame(8'h22, ^8'h22, 1'b1);
        after_frame("ovr");
        @(negedge sys_clk);
        check("ovr_data", {24'd0, rx_if.rx_data}, 32'h11);
        step();
        pulse_ready();
        @(negedge sys_clk);
        check("ovr_valid_clr", {31'd0, rx_if.rx_valid}, 0);
        check("ovr_overrun_clr", {31'd0, overrun}, 0);
        step();

        // Reset in the middle of data bit 4 of 0xFF.
        fork
            send_frame(8'hFF, ^8'hFF, 1'b1);
            begin
                hold(BitCyc * 5 + 80);
                rst = 1'b1;
                hold(2);
                @(negedge sys_clk);
                check("mrst_valid", {31'd0, rx_if.rx_valid}, 0);
                check("mrst_data", {24'd0, rx_if.rx_data}, 0);
                check("mrst_frame_err", {31'd0, frame_err}, 0);
                check("mrst_overrun", {31'd0, overrun}, 0);
                check("mrst_busy", {31'd0, busy}, 0);
                step();
                rst     = 1'b0;
                held    = 1'b0;
                ovr_exp = 1'b0;
            end
        join
        hold(20);
        set_ready(1'b1);
        model_frame(8'h5A, ^8'h5A, 1'b1);
        send_frame(8'h5A, ^8'h5A, 1'b1);
        after_frame("post_rst");
        set_ready(1'b0);

`ifdef UART_RX_PARITY_EN
        model_frame(8'h07, 1'b0, 1'b1);
        send_frame(8'h07, 1'b0, 1'b1);
        after_frame("par_bad");
        model_frame(8'h07, 1'b1, 1'b1);
        send_frame(8'h07, 1'b1, 1'b1);
        after_frame("par_good");
        @(negedge sys_clk);
        check("par_good_data", {24'd0, rx_if.rx_data}, 32'h07);
        step();
        pulse_ready();
`endif

        for (int k = 0; k < 14; k++) begin
            d    = 8'($urandom);
            stop = ($urandom_range(0, 7) != 0);
            par  = (^d) ^ (ParEn && ($urandom_range(0, 3) == 0));
            set_ready($urandom_range(0, 1) == 1);
            model_frame(d, par, stop);
            send_frame(d, par, stop);
            after_frame("rnd");
        end

        set_ready(1'b1);
        hold(5);
        set_ready(1'b0);
        hold(5);
        check("bytes_drained", byte_q.size(), 0);
        check("errs_drained", err_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
